// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the MEM stage and CP0.
// Picks the highest-priority cause, waits out busy data accesses, then commits, flushes and redirects fetch.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_busy_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    // state    | meaning
    // IDLE     | watching MEM stage for an exception or pending interrupt
    // WAIT_MEM | event latched, holding pipeline until the data access completes
    // COMMIT   | one cycle: excepttype to CP0, flush starts, fetch redirected
    // FLUSH    | remaining flush cycles, all inputs ignored
    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT, FLUSH} state_t;

    localparam logic [31:0] CODE_ERET = 32'h0000_000e;
    localparam logic [3:0]  FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t      state;
    logic [31:0] code_q;
    logic [3:0]  cnt;

    logic        int_pend;
    logic        any_flag;
    logic        detect;
    logic [31:0] code_d;

    assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    assign any_flag = adel_if_i | ri_i | syscall_i | break_i | ov_i | trap_i
                    | adel_i | ades_i | eret_i;
    assign detect   = mem_valid_i & (int_pend | any_flag);

    logic unused_ok;
    assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    always_comb begin
        code_d = 32'h0;
        if      (int_pend)  code_d = 32'h0000_0001;
        else if (adel_if_i) code_d = 32'h0000_0004;
        else if (ri_i)      code_d = 32'h0000_000a;
        else if (syscall_i) code_d = 32'h0000_0008;
        else if (break_i)   code_d = 32'h0000_0009;
        else if (ov_i)      code_d = 32'h0000_000c;
        else if (trap_i)    code_d = 32'h0000_000d;
        else if (adel_i)    code_d = 32'h0000_0004;
        else if (ades_i)    code_d = 32'h0000_0005;
        else if (eret_i)    code_d = CODE_ERET;
    end

    // Stall is combinational in IDLE so the instruction freezes in the same cycle it is detected.
    assign stall_o = (state == WAIT_MEM) | ((state == IDLE) & detect & mem_busy_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            code_q              <= 32'h0;
            cnt                 <= 4'd0;
            excepttype_o        <= 32'h0;
            current_inst_addr_o <= 32'h0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= 32'h0;
            flush_o             <= 1'b0;
            newpc_o             <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (detect) begin
                        code_q              <= code_d;
                        current_inst_addr_o <= pc_i;
                        is_in_delayslot_o   <= is_in_delayslot_i;
                        bad_addr_o          <= (~int_pend & adel_if_i) ? pc_i : mem_addr_i;
                        if (mem_busy_i) begin
                            state <= WAIT_MEM;
                        end else begin
                            state        <= COMMIT;
                            excepttype_o <= code_d;
                            flush_o      <= 1'b1;
                            newpc_o      <= (code_d == CODE_ERET) ? epc_i : EXC_VECTOR;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (!mem_busy_i) begin
                        state        <= COMMIT;
                        excepttype_o <= code_q;
                        flush_o      <= 1'b1;
                        newpc_o      <= (code_q == CODE_ERET) ? epc_i : EXC_VECTOR;
                    end
                end
                COMMIT: begin
                    excepttype_o <= 32'h0;
                    if (FLUSH_CYCLES <= 1) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                        newpc_o <= 32'h0;
                    end else begin
                        state <= FLUSH;
                        cnt   <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                        newpc_o <= 32'h0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: expected commits are queued at detection and checked when excepttype_o fires.
// A second instance built with FLUSH_CYCLES=1 shares the inputs and is checked only in the last phase.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_busy, in_ds;
    logic [31:0] pc, mem_addr, status, cause, epc;
    logic        adel_if, ri, syscall, brk, ov, trap, adel, ades, eret;

    logic [31:0] exc0, cia0, bad0, newpc0, exc1, cia1, bad1, newpc1;
    logic        ds0, stall0, flush0, ds1, stall1, flush1;

    logic [31:0] exc_s, cia_s, bad_s, newpc_s;
    logic        ds_s, stall_s, flush_s;

    int tests = 0;
    int fails = 0;
    int mode  = 0;

    always #5 clk = ~clk;

    exc_ctrl dut0 (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_busy_i(mem_busy), .pc_i(pc),
        .is_in_delayslot_i(in_ds), .mem_addr_i(mem_addr), .adel_if_i(adel_if), .ri_i(ri),
        .syscall_i(syscall), .break_i(brk), .ov_i(ov), .trap_i(trap), .adel_i(adel),
        .ades_i(ades), .eret_i(eret), .status_i(status), .cause_i(cause), .epc_i(epc),
        .excepttype_o(exc0), .current_inst_addr_o(cia0), .is_in_delayslot_o(ds0),
        .bad_addr_o(bad0), .stall_o(stall0), .flush_o(flush0), .newpc_o(newpc0)
    );

    exc_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_busy_i(mem_busy), .pc_i(pc),
        .is_in_delayslot_i(in_ds), .mem_addr_i(mem_addr), .adel_if_i(adel_if), .ri_i(ri),
        .syscall_i(syscall), .break_i(brk), .ov_i(ov), .trap_i(trap), .adel_i(adel),
        .ades_i(ades), .eret_i(eret), .status_i(status), .cause_i(cause), .epc_i(epc),
        .excepttype_o(exc1), .current_inst_addr_o(cia1), .is_in_delayslot_o(ds1),
        .bad_addr_o(bad1), .stall_o(stall1), .flush_o(flush1), .newpc_o(newpc1)
    );

    always_comb begin
        exc_s   = (mode == 1) ? exc1   : exc0;
        cia_s   = (mode == 1) ? cia1   : cia0;
        bad_s   = (mode == 1) ? bad1   : bad0;
        newpc_s = (mode == 1) ? newpc1 : newpc0;
        ds_s    = (mode == 1) ? ds1    : ds0;
        stall_s = (mode == 1) ? stall1 : stall0;
        flush_s = (mode == 1) ? flush1 : flush0;
    end

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] newpc;
        logic        ds;
        logic        chk_bad;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] code, input logic [31:0] p, input logic [31:0] b,
                        input logic cb, input logic [31:0] np, input logic d);
        exp_t e;
        e.code = code; e.pc = p; e.bad = b; e.chk_bad = cb; e.newpc = np; e.ds = d;
        sb.push_back(e);
    endtask

    task automatic clear_in();
        mem_valid = 0; mem_busy = 0; in_ds = 0;
        adel_if = 0; ri = 0; syscall = 0; brk = 0; ov = 0; trap = 0; adel = 0; ades = 0; eret = 0;
    endtask

    // One clock cycle: inputs already driven; check outputs mid-cycle, then advance.
    task automatic cyc(input logic ef, input logic es);
        exp_t e;
        #1;
        if (exc_s !== 32'h0) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", exc_s, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("excepttype", exc_s, e.code);
                chk("inst_addr", cia_s, e.pc);
                chk("delayslot", {31'h0, ds_s}, {31'h0, e.ds});
                chk("newpc", newpc_s, e.newpc);
                if (e.chk_bad) chk("bad_addr", bad_s, e.bad);
            end
        end
        chk("flush", {31'h0, flush_s}, {31'h0, ef});
        chk("stall", {31'h0, stall_s}, {31'h0, es});
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_exc"}, exc_s, 32'h0);
        chk({tag, "_flush"}, {31'h0, flush_s}, 32'h0);
        chk({tag, "_stall"}, {31'h0, stall_s}, 32'h0);
        chk({tag, "_newpc"}, newpc_s, 32'h0);
    endtask

    initial begin
        clear_in();
        rst = 1; pc = 0; mem_addr = 0; status = 0; cause = 0; epc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_zero("reset");
        chk("reset_inst_addr", cia_s, 32'h0);
        chk("reset_bad_addr", bad_s, 32'h0);

        // syscall, no busy: commit next cycle, flush exactly two cycles
        mem_valid = 1; syscall = 1; pc = 32'hBFC0_0100; mem_addr = 32'h0000_1234;
        push(32'h08, 32'hBFC0_0100, 32'h0, 0, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in();
        cyc(1, 0);
        chk("flush_newpc_held", newpc_s, 32'hBFC0_0380);
        chk("flush_exc_zero", exc_s, 32'h0);
        cyc(1, 0);
        cyc(0, 0);

        // ri beats ov and ades
        mem_valid = 1; ov = 1; ades = 1; ri = 1; pc = 32'hBFC0_0104;
        push(32'h0a, 32'hBFC0_0104, 32'h0, 0, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in();
        cyc(1, 0);
        cyc(1, 0);

        // pending interrupt beats ov, in a delay slot
        mem_valid = 1; ov = 1; in_ds = 1; pc = 32'hBFC0_0108;
        status = 32'h0000_0401; cause = 32'h0000_0400;
        push(32'h01, 32'hBFC0_0108, 32'h0, 0, 32'hBFC0_0380, 1);
        cyc(0, 0);
        clear_in(); status = 0; cause = 0;
        cyc(1, 0);
        cyc(1, 0);

        // adel with busy for three cycles; a higher flag during WAIT_MEM must not change the cause
        mem_valid = 1; adel = 1; mem_busy = 1; pc = 32'hBFC0_010C; mem_addr = 32'h8000_0003;
        push(32'h04, 32'hBFC0_010C, 32'h8000_0003, 1, 32'hBFC0_0380, 0);
        cyc(0, 1);
        adel = 0; ri = 1;
        cyc(0, 1);
        ri = 0;
        cyc(0, 1);
        mem_busy = 0;
        cyc(0, 1);
        clear_in();
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 0);

        // adel_if: bad address is the PC
        mem_valid = 1; adel_if = 1; pc = 32'hBFC0_0200; mem_addr = 32'h0000_0055;
        push(32'h04, 32'hBFC0_0200, 32'hBFC0_0200, 1, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in();
        cyc(1, 0);
        cyc(1, 0);

        // eret redirects to EPC; flags during COMMIT/FLUSH are ignored
        mem_valid = 1; eret = 1; pc = 32'hBFC0_0300; epc = 32'hBFC0_1234;
        push(32'h0e, 32'hBFC0_0300, 32'h0, 0, 32'hBFC0_1234, 0);
        cyc(0, 0);
        clear_in(); mem_valid = 1; syscall = 1; brk = 1;
        cyc(1, 0);
        chk("eret_newpc_held", newpc_s, 32'hBFC0_1234);
        cyc(1, 0);
        clear_in();
        cyc(0, 0);
        cyc(0, 0);

        // reset in WAIT_MEM discards the event
        mem_valid = 1; adel = 1; mem_busy = 1; pc = 32'hBFC0_0400;
        cyc(0, 1);
        clear_in(); mem_busy = 1;
        cyc(0, 1);
        rst = 1;
        cyc(0, 1);
        rst = 0; mem_busy = 0;
        check_zero("rst_wait");
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);

        // reset in COMMIT
        mem_valid = 1; syscall = 1; pc = 32'hBFC0_0500;
        push(32'h08, 32'hBFC0_0500, 32'h0, 0, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in(); rst = 1;
        cyc(1, 0);
        rst = 0;
        check_zero("rst_commit");
        cyc(0, 0);

        // reset in FLUSH
        mem_valid = 1; syscall = 1; pc = 32'hBFC0_0504;
        push(32'h08, 32'hBFC0_0504, 32'h0, 0, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in();
        cyc(1, 0);
        rst = 1;
        cyc(1, 0);
        rst = 0;
        check_zero("rst_flush");
        cyc(0, 0);

        // FLUSH_CYCLES=1 instance: back-to-back syscalls two cycles apart
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        mode = 1;
        check_zero("reset1");
        mem_valid = 1; syscall = 1; pc = 32'hBFC0_0600;
        push(32'h08, 32'hBFC0_0600, 32'h0, 0, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in();
        cyc(1, 0);
        mem_valid = 1; syscall = 1; pc = 32'hBFC0_0608;
        push(32'h08, 32'hBFC0_0608, 32'h0, 0, 32'hBFC0_0380, 0);
        cyc(0, 0);
        clear_in();
        cyc(1, 0);
        cyc(0, 0);

        // flags without mem_valid do nothing
        syscall = 1; ov = 1; mem_busy = 1; status = 32'h0000_0401; cause = 32'h0000_0400;
        cyc(0, 0);
        cyc(0, 0);
        clear_in(); status = 0; cause = 0;
        cyc(0, 0);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
